// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer for pipeline stage 1.
// Owns the PC, issues one word request at a time to a variable-latency instruction memory
// (req/ack), holds the fetched word for decode (valid/ready), and applies jump/branch
// redirects, discarding any fetch that a redirect has made stale.
// Optional build macro: IFETCH_PERF_EN adds perf_fetched / perf_stall counters.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  input  logic        branch,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold
  } state_e;

  localparam logic [31:0] WordMask = 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  // Address of the request still in flight after a redirect has moved pc_q on.
  logic [31:0] req_addr_q, req_addr_d;
  logic        squash_q, squash_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // Jump wins over branch; targets are always forced word-aligned.
  assign redirect = jump | branch;
  assign target   = (jump ? jump_addr : branch_addr) & WordMask;
  assign pc_plus4 = pc_q + 32'd4;

  // Next-state and datapath updates for the fetch sequencer.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    squash_d   = squash_q;
    inst_d     = inst_q;
    ipc_d      = ipc_q;
    ipc4_d     = ipc4_q;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        if (redirect) begin
          pc_d = target;
        end
      end

      StFetch: begin
        if (imem_ack) begin
          // The outstanding request completes this cycle either way.
          squash_d = 1'b0;
          if (redirect) begin
            pc_d = target;
          end else if (!squash_q) begin
            inst_d  = imem_rdata;
            ipc_d   = pc_q;
            ipc4_d  = pc_plus4;
            pc_d    = pc_plus4;
            state_d = StHold;
          end
        end else if (redirect) begin
          // Keep presenting the already-issued address until its ack arrives.
          pc_d = target;
          if (!squash_q) begin
            squash_d   = 1'b1;
            req_addr_d = pc_q;
          end
        end
      end

      StHold: begin
        // A redirect discards an unaccepted word; with if_ready it counts as consumed.
        if (redirect || if_ready) begin
          state_d = StFetch;
        end
        if (redirect) begin
          pc_d = target;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset drops any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC & WordMask;
      req_addr_q <= RESET_PC & WordMask;
      squash_q   <= 1'b0;
      inst_q     <= 32'd0;
      ipc_q      <= 32'd0;
      ipc4_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      squash_q   <= squash_d;
      inst_q     <= inst_d;
      ipc_q      <= ipc_d;
      ipc4_q     <= ipc4_d;
    end
  end

  // Outputs decode directly from registered state.
  always_comb begin
    imem_req  = (state_q == StFetch);
    imem_addr = squash_q ? req_addr_q : pc_q;
    if_valid  = (state_q == StHold);
    if_inst   = inst_q;
    if_pc     = ipc_q;
    if_pc4    = ipc4_q;
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] fetched_q, stall_q;

  // Handshake and memory-stall counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      if (if_valid && if_ready) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if (imem_req && !imem_ack) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios followed by randomized traffic.
// A reference model predicts the in-order stream of accepted instructions; a monitor
// pops and compares each accepted word against it.
module tb_ifetch_ctrl;

  localparam logic [31:0] RstPc  = 32'h0000_0000;
  localparam logic [31:0] WrapPc = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump = 1'b0, branch = 1'b0, imem_ack = 1'b0, if_ready = 1'b0;
  logic [31:0] jump_addr = '0, branch_addr = '0, imem_rdata = '0;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_inst, if_pc, if_pc4;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_inst, w_pc, w_pc4;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, w_pf, w_ps;
`endif

  always #5 clk = ~clk;

  ifetch_ctrl #(.RESET_PC(RstPc)) u_dut (
    .clk(clk), .rst(rst), .jump(jump), .jump_addr(jump_addr), .branch(branch),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4)
`ifdef IFETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  // Second instance starting at the top of the address space, free-running ack and ready.
  ifetch_ctrl #(.RESET_PC(WrapPc)) u_wrap (
    .clk(clk), .rst(rst), .jump(1'b0), .jump_addr(32'd0), .branch(1'b0),
    .branch_addr(32'd0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(1'b1), .imem_rdata(32'h1234_5678), .if_valid(w_valid), .if_ready(1'b1),
    .if_inst(w_inst), .if_pc(w_pc), .if_pc4(w_pc4)
`ifdef IFETCH_PERF_EN
    , .perf_fetched(w_pf), .perf_stall(w_ps)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          hs_n = 0;
  int          bc_fetch = 0;
  int          bc_stall = 0;
  int          lat = 0;
  bit          rand_lat = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc = RstPc;
  logic [31:0] w_pcs[$];
  logic [31:0] w_pc4s[$];

  // Memory contents: distinct word for every aligned address; mem(16) = 8c000001.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h8c00_0001 + (a - 32'd16) * 32'h0001_0003;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model for that cycle.
  task automatic cyc(input logic j, input logic [31:0] ja, input logic b,
                     input logic [31:0] ba, input logic rdy, input logic r);
    @(posedge clk);
    #1;
    rst = r; jump = j; jump_addr = ja; branch = b; branch_addr = ba;
    if_ready = r ? 1'b0 : rdy;
    if (r) begin
      exp_q.delete();
      exp_pc   = RstPc;
      bc_fetch = 0;
      bc_stall = 0;
    end else begin
      if (if_valid === 1'b1 && rdy) begin
        exp_q.push_back(exp_pc);
        exp_pc = exp_pc + 32'd4;
        bc_fetch++;
      end
      if (j) exp_pc = ja & 32'hFFFF_FFFC;
      else if (b) exp_pc = ba & 32'hFFFF_FFFC;
    end
  endtask

  // Memory responder: fixed or random latency, checks address stability while waiting.
  bit          pend = 1'b0;
  logic [31:0] pend_addr;
  int          waited, lat_cur;
  always @(posedge clk) begin
    #2;
    if (imem_req === 1'b1) begin
      if (!pend) begin
        pend      = 1'b1;
        waited    = 0;
        pend_addr = imem_addr;
        lat_cur   = rand_lat ? int'($urandom_range(0, 3)) : lat;
      end else begin
        chk("addr_stable", imem_addr, pend_addr);
      end
      if (waited >= lat_cur) begin
        imem_ack   = 1'b1;
        imem_rdata = mem(pend_addr);
        pend       = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        waited++;
        if (!rst) bc_stall++;
      end
    end else begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      pend       = 1'b0;
    end
  end

  // Scoreboard monitor: every accepted word must be the next one the model predicts.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst === 1'b0 && if_valid === 1'b1 && if_ready === 1'b1) begin
      hs_n++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_handshake actual_pc=%h required=none", if_pc);
      end else begin
        e = exp_q.pop_front();
        chk("if_pc", if_pc, e);
        chk("if_pc4", if_pc4, e + 32'd4);
        chk("if_inst", if_inst, mem(e));
      end
    end
  end

  // Capture the first two words delivered by the wrap-around instance.
  always @(negedge clk) begin
    if (w_valid === 1'b1 && w_pcs.size() < 2) begin
      w_pcs.push_back(w_pc);
      w_pc4s.push_back(w_pc4);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_inst"}, if_inst, 32'd0);
    chk({tag, "_pc"}, if_pc, 32'd0);
    chk({tag, "_pc4"}, if_pc4, 32'd0);
    chk({tag, "_addr"}, imem_addr, RstPc);
`ifdef IFETCH_PERF_EN
    chk({tag, "_perf_fetched"}, perf_fetched, 32'd0);
    chk({tag, "_perf_stall"}, perf_stall, 32'd0);
`endif
  endtask

  initial begin
    logic [7:0] pat_v, pat_r;
    logic       r, j, b, rdy;
    logic [31:0] ja, ba;

    // Reset values, then best-case streaming: one word every two cycles.
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk_reset_outputs("reset");
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("req_at_release", 32'(imem_req), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
      pat_v = {pat_v[6:0], if_valid};
      pat_r = {pat_r[6:0], imem_req};
    end
    chk("valid_pattern", 32'(pat_v), 32'h55);
    chk("req_pattern", 32'(pat_r), 32'hAA);

    // Decode stalls five cycles on the word at 0x10.
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      chk("hold_inst", if_inst, 32'h8c00_0001);
      chk("hold_pc", if_pc, 32'h10);
      chk("hold_valid_noreq", {30'd0, if_valid, imem_req}, 32'd2);
    end
    lat = 3;
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Jump during a slow fetch: old address held until ack, then refetch at 0x40.
    cyc(1'b1, 32'h40, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("squash_addr_0", imem_addr, 32'h14);
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("squash_addr_1", imem_addr, 32'h14);
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("squash_addr_2", imem_addr, 32'h14);
    lat = 0;
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("squash_addr_ack", imem_addr, 32'h14);
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'h40);

    // Jump and branch together: jump wins.
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, 32'h80, 1'b1, 32'h20, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("prio_addr", imem_addr, 32'h80);
    // Unaligned branch while decode is stalled: held word dropped, fetch at 0x20.
    cyc(1'b0, 32'd0, 1'b1, 32'h23, 1'b0, 1'b0);
    lat = 3;
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("align_addr", imem_addr, 32'h20);
    chk("align_valid", 32'(if_valid), 32'd0);

    // Reset while waiting on an ack.
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
    lat = 0;
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk_reset_outputs("midreset");
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("restart_addr", imem_addr, RstPc);
    chk("restart_req", 32'(imem_req), 32'd1);

    // Randomized traffic.
    rand_lat = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(0, 499) == 0);
      j   = ($urandom_range(0, 19) == 0);
      b   = ($urandom_range(0, 14) == 0);
      ja  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      ba  = $urandom;
      rdy = ($urandom_range(0, 3) != 0);
      cyc(j, ja, b, ba, rdy, r);
    end

    // Drain and settle, then final bookkeeping checks.
    rand_lat = 1'b0;
    lat = 0;
    for (int i = 0; i < 8; i++) cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("enough_handshakes", 32'(hs_n >= 300), 32'd1);
`ifdef IFETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'(bc_fetch));
    chk("perf_stall", perf_stall, 32'(bc_stall));
`endif
    chk("wrap_count", 32'(w_pcs.size()), 32'd2);
    if (w_pcs.size() == 2) begin
      chk("wrap_pc0", w_pcs[0], 32'hFFFF_FFFC);
      chk("wrap_pc4_0", w_pc4s[0], 32'd0);
      chk("wrap_pc1", w_pcs[1], 32'd0);
      chk("wrap_pc4_1", w_pc4s[1], 32'd4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
